// File: rtl/uart_pkg.sv
// Shared defaults for the UART receive-path controller.
// The 9600-baud divisor assumes a 50 MHz clock and 16x oversampling.
package uart_pkg;

    localparam int DBIT_DEF   = 8;
    localparam int DVSR_W_DEF = 11;
    localparam int ADDR_W_DEF = 3;

    // 326 clk per tick: 50e6 / (16 * 9600) rounded, minus one for the 0..dvsr count.
    localparam int DVSR_9600_50M = 325;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// Registered count/full/empty; the head entry is always visible on rd_data.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int DW = DBIT_DEF,
    parameter int AW = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          push, pop;
    fifo_op_e      op;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign pop  = rd_req & ~empty_q;
    assign push = wr_req & (~full_q | pop);
    assign op   = fifo_op_e'({push, pop});

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case (op)
            FIFO_PUSH: count_d = count_q + 1'b1;
            FIFO_POP:  count_d = count_q - 1'b1;
            default:   count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    // Storage is never cleared, so the head is masked while empty.
    assign rd_data = empty_q ? '0 : mem_q[rptr_q];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: oversampling tick generator, byte FIFO
// between Receiver and consumer, and sticky overrun status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int DVSR_W = DVSR_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DVSR_W-1:0] dvsr,
    output logic              s_tick,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   rx_data,
    input  logic              rd_en,
    output logic [DBIT-1:0]   rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              clr_err
);

    logic [DVSR_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_hit;
    logic              overrun_q, overrun_d;
    logic              wr_req;
    logic              drop;

    // >= rather than == so a live dvsr decrease below the count still wraps.
    assign tick_hit = (tick_cnt_q >= dvsr);

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (!en || tick_hit) tick_cnt_d = '0;
    end

    assign s_tick = en & ~reset & tick_hit;

    assign wr_req    = en & rx_done_tick;
    assign drop      = wr_req & full & ~rd_en;
    assign overrun_d = drop | (overrun_q & ~clr_err);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign overrun = overrun_q;

    rx_fifo #(
        .DW (DBIT),
        .AW (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_req  (wr_req),
        .wr_data (rx_data),
        .rd_req  (rd_en),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller for the UART receive path between the serial Receiver and the keyboard-to-monitor display logic. It configures the Receiver's oversampling rate by generating the s_tick strobe from a programmable divisor. It also captures each byte the Receiver completes into a small first-word-fall-through FIFO. It exposes a pop handshake to the consumer and reports overrun, full and empty status.

Parameters:
DBIT, 8, data bits per received byte; width of rx_data and rd_data.
DVSR_W, 11, width of the baud divisor input.
ADDR_W, 3, FIFO address width; depth = 2**ADDR_W = 8 entries.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  receive-path enable
dvsr  input  DVSR_W  tick divisor; s_tick period = dvsr+1 clk cycles
s_tick  output  1  one-cycle oversampling strobe to Receiver
rx_done_tick  input  1  one-cycle byte-complete strobe from Receiver
rx_data  input  DBIT  byte from Receiver (dout), valid with rx_done_tick
rd_en  input  1  consumer pop request
rd_data  output  DBIT  FIFO head byte (valid when empty=0)
empty  output  1  FIFO holds 0 bytes
full  output  1  FIFO holds 2**ADDR_W bytes
count  output  ADDR_W+1  bytes currently held
overrun  output  1  sticky: a byte was dropped because FIFO was full
clr_err  input  1  clears overrun

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high.
- Reset values: tick counter 0, s_tick 0, FIFO pointers 0, count 0, empty 1, full 0, overrun 0, rd_data 0.
- Tick generator:
  - Counter runs 0..dvsr. s_tick=1 for exactly the cycle in which counter==dvsr, then the counter wraps to 0.
  - dvsr=0 gives s_tick every cycle.
  - dvsr is sampled live. If dvsr is lowered below the current count, the counter wraps on the next cycle: it detects counter>=dvsr, pulses s_tick and reloads 0.
  - en=0 holds the counter at 0 and s_tick=0. On the first cycle with en=1 the count starts at 0, so the first tick lands dvsr cycles later.
- Push:
  - rx_done_tick=1 with en=1 and full=0 writes rx_data at the write pointer. The write pointer wraps modulo depth.
  - rx_done_tick while en=0 is ignored.
- Pop:
  - rd_en=1 with empty=0 advances the read pointer.
  - rd_data always shows the head entry combinationally from the storage array (FWFT). After a pop, the next entry is visible the following cycle.
  - rd_en with empty=1 is ignored; no pointer change and no error.
- Simultaneous push and pop:
  - Not empty, not full: both occur; count unchanged.
  - Full: both occur; the pop frees the slot, the new byte is stored, no overrun.
  - Empty: the push occurs, the pop is ignored, and count becomes 1.
- Overrun:
  - rx_done_tick (en=1) while full=1 and rd_en=0 drops the byte and sets overrun=1 on the next edge.
  - overrun holds until clr_err=1. If clr_err and a new overrun event occur in the same cycle, overrun stays 1 (set wins).
- Status outputs:
  - count, empty and full are registered, updated on the same edge as the pointers.
  - full = (count==2**ADDR_W); empty = (count==0).
- Reset mid-operation: all state returns to reset values immediately. FIFO contents are not cleared but become unreachable because the pointers reset.

Decomposition:
- Shared package uart_pkg: DBIT, DVSR_W, ADDR_W defaults, and the standard divisor constant DVSR_9600_50M = 325. That constant gives a 16x oversampling tick of 326 clk per tick, matching the existing bench cadence.
- One natural sub-module: rx_fifo, a synchronous FWFT FIFO with push, pop, count, full and empty.
- The tick generator stays inline.

Test Plan:
1. Reset, en=1, dvsr=3 -> s_tick pulses at cycles 3, 7, 11 after enable, each exactly 1 cycle wide; dvsr=0 -> s_tick constant 1.
2. Push 0x41, 0x42, 0x43 via rx_done_tick, then 3 pops -> rd_data reads 0x41, 0x42, 0x43 in order; count goes 3->0; empty=1 at end.
3. Push 8 bytes 0x10..0x17 -> full=1, count=8. A 9th push of 0x18 -> overrun=1, the byte is dropped, and pops return 0x10..0x17. clr_err -> overrun=0.
4. Fill to 8, then push 0x55 and pop in the same cycle -> no overrun, count stays 8, and the last pop sequence ends with 0x55. Write pointer wraps correctly.
5. Empty FIFO: simultaneous push 0xA5 and rd_en -> count=1, rd_data=0xA5. rd_en on empty -> no change.
6. Assert reset mid-stream with count=5 and the tick counter mid-period -> count=0, empty=1, s_tick=0, overrun=0 immediately, without waiting for a clk edge.
